lcg_stim_gen: RTL and testbench

- Synthesizable stimulus source sitting directly upstream of the fuzzed `top` DUT; drives its flat input vector.
- Reproduces the bench's deterministic 32-bit LCG stream: state = state*32'h41C64E6D + 32'h3039, mod 2^32.
- Assembles each OUT_W-bit vector one 32-bit chunk per clock and hands it off with a valid/ready handshake.
- Runs a programmable number of vectors, then reports done; used for on-chip and emulation fuzz runs.

---
 rtl/lcg_stim_pkg.sv | 12 +
 rtl/lcg_stim_gen_core.sv | 18 +
 rtl/lcg_stim_gen.sv | 114 +++++++++++
 tb/tb_lcg_stim_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcg_stim_pkg.sv
// lcg_stim_pkg: shared constants, FSM encoding and LCG helpers for lcg_stim_gen
package lcg_stim_pkg;
  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h3039;
  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;
  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    return s * LCG_MUL + LCG_INC;
  endfunction
  function automatic int nchunk(input int w);
    return (w + 31) / 32;
  endfunction
endpackage

// File: rtl/lcg_stim_gen_core.sv
// lcg_core: 32-bit LCG state register with seed load and single-step advance
module lcg_core
  import lcg_stim_pkg::*;
#(
  parameter logic [31:0] SEED_DEFAULT = 32'd2167613558
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SEED_DEFAULT;
    else if (load) state <= seed;
    else if (step) state <= lcg_next(state);
endmodule

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG-driven vector source, one 32-bit chunk per clock, valid/ready handoff.
// Define LCG_STIM_PREFETCH_EN to fill the next vector while the current one is presented.
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int          OUT_W        = 137,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] SEED_DEFAULT = 32'd2167613558
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      seed_i,
  input  logic             seed_load_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cycles_i,
  output logic [OUT_W-1:0] vec_o,
  output logic             vec_valid_o,
  input  logic             vec_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] vec_count_o
);
  localparam int NCH = nchunk(OUT_W);
  localparam int KW = $clog2(NCH + 1);
  state_t st;
  logic [KW-1:0] k;
  logic [OUT_W-1:0] shadow, sh_n;
  logic [CNT_W:0] cnt;
  logic [CNT_W-1:0] lim;
  logic [31:0] lcg_state, nxt;
  logic idle, fill, last, hs, fin;
`ifdef LCG_STIM_PREFETCH_EN
  logic sh_full;
`endif
  lcg_core #(.SEED_DEFAULT(SEED_DEFAULT)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (idle && seed_load_i),
    .step (fill),
    .seed (seed_i),
    .state(lcg_state)
  );
  assign idle = st == IDLE || st == DONE;
  assign hs = st == PRESENT && vec_valid_o && vec_ready_i;
  // one extra count bit so an all-ones limit still terminates
  assign fin = cnt + 1'b1 == {1'b0, lim} + 1'b1;
`ifdef LCG_STIM_PREFETCH_EN
  assign fill = st == FILL || (st == PRESENT && !sh_full && cnt < {1'b0, lim});
`else
  assign fill = st == FILL;
`endif
  assign last = fill && k == KW'(NCH - 1);
  assign nxt = lcg_next(lcg_state);
  assign vec_count_o = cnt[CNT_W-1:0];
  always_comb begin
    sh_n = shadow;
    for (int b = 0; b < OUT_W; b++) if (b / 32 == int'(k)) sh_n[b] = nxt[b % 32];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      k <= '0;
      shadow <= '0;
      cnt <= '0;
      lim <= '0;
      vec_o <= '0;
      vec_valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
`ifdef LCG_STIM_PREFETCH_EN
      sh_full <= 1'b0;
`endif
    end else begin
      if (fill) begin
        shadow <= sh_n;
        k <= last ? '0 : k + 1'b1;
      end
      if (idle && start_i) begin
        lim <= cycles_i;
        cnt <= '0;
        done_o <= 1'b0;
        busy_o <= 1'b1;
        k <= '0;
        st <= FILL;
      end
      if (st == FILL && last) begin
        vec_o <= sh_n;
        vec_valid_o <= 1'b1;
        st <= PRESENT;
      end
`ifdef LCG_STIM_PREFETCH_EN
      if (st == PRESENT && last) sh_full <= 1'b1;
`endif
      if (hs) begin
        cnt <= cnt + 1'b1;
        if (fin) begin
          st <= DONE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          vec_valid_o <= 1'b0;
        end
`ifdef LCG_STIM_PREFETCH_EN
        else if (sh_full || last) begin
          vec_o <= sh_full ? shadow : sh_n;
          sh_full <= 1'b0;
        end
`endif
        else begin
          vec_valid_o <= 1'b0;
          st <= FILL;
        end
      end
    end
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: scoreboard bench for lcg_stim_gen against an arithmetic LCG stream model
module tb_lcg_stim_gen;
  localparam int OUT_W = 137;
  localparam int CNT_W = 32;
  localparam int NCH = (OUT_W + 31) / 32;
  localparam logic [31:0] SEED_DEF = 32'd2167613558;
  logic clk = 1'b0, rst = 1'b1, seed_load_i = 1'b0, start_i = 1'b0, vec_ready_i = 1'b0;
  logic [31:0] seed_i = '0;
  logic [CNT_W-1:0] cycles_i = '0;
  logic [OUT_W-1:0] vec_o;
  logic vec_valid_o, busy_o, done_o;
  logic [CNT_W-1:0] vec_count_o;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] last_vec = '0, held;
  logic [31:0] m;
  int checks = 0, errors = 0, rdy_mode = 0, wcnt = 0, drops = 0;
  logic watch = 1'b0, seen_v = 1'b0;

  lcg_stim_gen dut (
    .clk        (clk),
    .rst        (rst),
    .seed_i     (seed_i),
    .seed_load_i(seed_load_i),
    .start_i    (start_i),
    .cycles_i   (cycles_i),
    .vec_o      (vec_o),
    .vec_valid_o(vec_valid_o),
    .vec_ready_i(vec_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .vec_count_o(vec_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ready policy: 0 always, 1 random, 2 held low, 3 slow consumer, other = left to caller
  task automatic tick();
    logic pv, pr;
    pv = vec_valid_o;
    pr = vec_ready_i;
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: vec_ready_i = 1'b1;
      1: vec_ready_i = 1'($urandom_range(0, 1));
      2: vec_ready_i = 1'b0;
      3: begin
        wcnt = (pv && pr) ? 0 : (vec_valid_o ? wcnt + 1 : wcnt);
        vec_ready_i = wcnt >= 7;
      end
      default: ;
    endcase
  endtask

  task automatic push_run(input int n);
    logic [OUT_W-1:0] v;
    for (int i = 0; i <= n; i++) begin
      v = '0;
      for (int j = 0; j < NCH; j++) begin
        m = m * 32'h41C64E6D + 32'h3039;
        for (int b = 0; b < 32; b++) if (j * 32 + b < OUT_W) v[j*32+b] = m[b];
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic start_run(input int n);
    push_run(n);
    cycles_i = CNT_W'(n);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done_o && t < 2000) begin
      tick();
      t++;
    end
    checks++;
    if (!done_o) begin
      errors++;
      $display("FAIL %s_timeout: done_o=0 after %0d cycles, expected 1", name, t);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (watch && busy_o) begin
        if (vec_valid_o) seen_v = 1'b1;
        else if (seen_v) drops++;
      end
      if (vec_valid_o && vec_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vec: got %h expected none", vec_o);
        end else chk("vec", vec_o, exp_q.pop_front());
        last_vec = vec_o;
      end
    end
  endtask

  initial begin
    int t;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vec_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", vec_count_o, 0);
    chk("rst_vec", vec_o, 0);
    rst = 1'b0;
    // seed 0, single vector
    rdy_mode = 0;
    seed_i = '0;
    seed_load_i = 1'b1;
    tick();
    seed_load_i = 1'b0;
    m = '0;
    start_run(0);
    wait_done("t1");
    chk("t1_lo", last_vec[31:0], 32'h00003039);
    chk("t1_hi", last_vec[63:32], 32'hD3DC167E);
    chk("t1_done", done_o, 1);
    chk("t1_count", vec_count_o, 1);
    chk("t1_busy", busy_o, 0);
    // seed load and start together: fill uses the new seed
    seed_i = 32'hCAFEF00D;
    seed_load_i = 1'b1;
    m = 32'hCAFEF00D;
    start_run(1);
    seed_load_i = 1'b0;
    wait_done("t1b");
    chk("t1b_count", vec_count_o, 2);
    // default stream after async reset, random backpressure
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_q.delete();
    m = SEED_DEF;
    rdy_mode = 1;
    start_run(3);
    wait_done("t3");
    chk("t3_count", vec_count_o, 4);
    chk("t3_qempty", exp_q.size(), 0);
    // backpressure: hold ready low, then a single accept
    rdy_mode = 2;
    start_run(1);
    t = 0;
    while (!vec_valid_o && t < 50) begin
      tick();
      t++;
    end
    chk("t4_valid", vec_valid_o, 1);
    held = vec_o;
    repeat (10) begin
      tick();
      chk("t4_hold", vec_o, held);
      chk("t4_hold_v", vec_valid_o, 1);
    end
    chk("t4_cnt0", vec_count_o, 0);
    rdy_mode = 4;
    vec_ready_i = 1'b1;
    tick();
    vec_ready_i = 1'b0;
    chk("t4_cnt1", vec_count_o, 1);
    repeat (8) tick();
    chk("t4_cnt1_held", vec_count_o, 1);
    rdy_mode = 0;
    wait_done("t4");
    chk("t4_count", vec_count_o, 2);
    // start/seed pulses while busy are ignored
    rdy_mode = 1;
    start_run(2);
    repeat (3) tick();
    chk("t5_busy", busy_o, 1);
    seed_i = 32'h1234;
    seed_load_i = 1'b1;
    start_i = 1'b1;
    cycles_i = 50;
    tick();
    seed_load_i = 1'b0;
    start_i = 1'b0;
    wait_done("t5");
    chk("t5_count", vec_count_o, 3);
    chk("t5_qempty", exp_q.size(), 0);
    // async reset during fill of chunk 2
    rdy_mode = 0;
    start_run(1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_valid", vec_valid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 0);
    chk("t6_count", vec_count_o, 0);
    chk("t6_vec", vec_o, 0);
    exp_q.delete();
    m = SEED_DEF;
    tick();
    rst = 1'b0;
    start_run(1);
    wait_done("t6");
    chk("t6_count2", vec_count_o, 2);
    // slow consumer; with prefetch valid must not drop between vectors
    rdy_mode = 3;
    wcnt = 0;
    drops = 0;
    seen_v = 1'b0;
    watch = 1'b1;
    start_run(7);
    wait_done("t7");
    watch = 1'b0;
    chk("t7_count", vec_count_o, 8);
`ifdef LCG_STIM_PREFETCH_EN
    chk("t7_no_bubble", drops, 0);
`endif
    // follow-on run catches any LCG advance past the last vector
    rdy_mode = 1;
    start_run(0);
    wait_done("t8");
    chk("t8_count", vec_count_o, 1);
    chk("t8_qempty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
